// File: rtl/score_keeper_if.sv
// Goal/restart inputs and score/display outputs of the score_keeper block.
// The master drives the goal and restart levels. The slave (score_keeper) returns scores, match status and the 7-segment scan.
// This bundle has no flow control. All signals are plain levels.
interface score_keeper_if;
  logic       pl1_goal;    // level, rising edge = player 1 goal
  logic       pl2_goal;    // level, rising edge = player 2 goal
  logic       restart;     // level, rising edge = new match
  logic [7:0] pl1_score;   // BCD {tens, ones}
  logic [7:0] pl2_score;   // BCD {tens, ones}
  logic       match_over;  // high while a winner is declared
  logic [1:0] winner;      // 01 pl1, 10 pl2, 11 tie, 00 none
  logic [6:0] seg;         // {g,f,e,d,c,b,a}, active-low
  logic [3:0] an;          // digit enables, active-low
  logic       dp;          // decimal point, active-low

  modport master (
    output pl1_goal, pl2_goal, restart,
    input  pl1_score, pl2_score, match_over, winner, seg, an, dp
  );

  modport slave (
    input  pl1_goal, pl2_goal, restart,
    output pl1_score, pl2_score, match_over, winner, seg, an, dp
  );
endinterface

// File: rtl/score_keeper.sv
// Purpose: match scoring with BCD scores, win detection and a 4-digit multiplexed 7-segment scan.
// Latency: an input edge updates the scores 2 clk edges after it is first sampled. The display outputs are registered and trail the digit index by one cycle.
// Backpressure: none. Events arrive as levels and are always consumed.
// Ports: clk, clr_n (async active-low) and sk (slave modport).
//   In:  pl1_goal, pl2_goal, restart.
//   Out: pl1_score, pl2_score, match_over, winner, seg, an, dp.
module score_keeper #(
  parameter int WIN_SCORE   = 7,
  parameter int REFRESH_DIV = 100000
) (
  input logic           clk,
  input logic           clr_n,
  score_keeper_if.slave sk
);

  localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
  localparam int         RW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {PLAY = 1'b0, OVER = 1'b1} state_t;

  // ---------------- input conditioning ----------------
  // Bit 0 = pl1_goal, bit 1 = pl2_goal, bit 2 = restart.
  logic [2:0] raw;
  logic [2:0] s1_q, s2_q, s3_q;
  logic [2:0] evt;

  assign raw = {sk.restart, sk.pl2_goal, sk.pl1_goal};

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Cleared sync flops make a level that is already high at reset release count once.
  assign evt = s2_q & ~s3_q;

  // ---------------- scoring FSM ----------------
  state_t     state_q, state_d;
  logic [7:0] p1_q, p1_d, p2_q, p2_d;
  logic [1:0] winner_q, winner_d;
  logic [7:0] p1_new, p2_new;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= PLAY;
      p1_q     <= '0;
      p2_q     <= '0;
      winner_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      winner_q <= winner_d;
    end
  end

  always_comb begin
    p1_new   = evt[0] ? bcd_inc(p1_q) : p1_q;
    p2_new   = evt[1] ? bcd_inc(p2_q) : p2_q;
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    winner_d = winner_q;
    if (evt[2]) begin
      // Restart takes priority and discards any coincident goal.
      state_d  = PLAY;
      p1_d     = '0;
      p2_d     = '0;
      winner_d = 2'b00;
    end else if (state_q == PLAY) begin
      p1_d = p1_new;
      p2_d = p2_new;
      if (p1_new == WIN_BCD || p2_new == WIN_BCD) begin
        state_d  = OVER;
        winner_d = {p2_new == WIN_BCD, p1_new == WIN_BCD};
      end
    end
  end

  assign sk.pl1_score  = p1_q;
  assign sk.pl2_score  = p2_q;
  assign sk.match_over = (state_q == OVER);
  assign sk.winner     = winner_q;

  // ---------------- display scan ----------------
  logic [RW-1:0] refresh_q, refresh_d;
  logic [1:0]    idx_q, idx_d;
  logic          wrap;

  assign wrap      = (refresh_q == RW'(REFRESH_DIV - 1));
  assign refresh_d = wrap ? '0 : refresh_q + 1'b1;
  assign idx_d     = wrap ? idx_q + 2'd1 : idx_q;

  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  logic [6:0] seg_q, seg_d;
  logic [3:0] an_q, an_d;
  logic       dp_q, dp_d;
  logic [3:0] digit;
  logic       blank;

  always_comb begin
    an_d  = 4'b1110;
    digit = p2_q[3:0];
    blank = 1'b0;
    case (idx_q)
      2'd0: begin
        an_d  = 4'b1110;
        digit = p2_q[3:0];
      end
      2'd1: begin
        an_d  = 4'b1101;
        digit = p2_q[7:4];
        blank = (p2_q[7:4] == 4'd0);
      end
      2'd2: begin
        an_d  = 4'b1011;
        digit = p1_q[3:0];
      end
      default: begin
        an_d  = 4'b0111;
        digit = p1_q[7:4];
        blank = (p1_q[7:4] == 4'd0);
      end
    endcase
    seg_d = blank ? 7'h7F : seg_lut(digit);
    // The point marks the winner's ones digit. Both ones digits are marked on a tie.
    dp_d  = ~((state_q == OVER) &&
              ((idx_q == 2'd2 && winner_q[0]) || (idx_q == 2'd0 && winner_q[1])));
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      refresh_q <= '0;
      idx_q     <= 2'd0;
      seg_q     <= 7'b1000000;
      an_q      <= 4'b1110;
      dp_q      <= 1'b1;
    end else begin
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
    end
  end

  assign sk.seg = seg_q;
  assign sk.an  = an_q;
  assign sk.dp  = dp_q;

endmodule

// File: tb/tb_score_keeper.sv
// Testbench for score_keeper. A stimulus process issues goal and restart events and predicts the resulting match state.
// A monitor process updates the model at each due cycle and compares scores and the display scan every cycle.
module tb_score_keeper;
  localparam int WIN = 12;
  localparam int DIV = 4;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  int   cyc;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  score_keeper_if sk();

  score_keeper #(.WIN_SCORE(WIN), .REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .sk    (sk)
  );

  // Cycles since reset release, counted in rising edges.
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int         s1;
    int         s2;
    bit         over;
    logic [1:0] win;
  } mstate_t;

  typedef struct {
    int      due;
    mstate_t st;
  } exp_t;

  exp_t    q[$];
  mstate_t m;         // stimulus-side prediction
  mstate_t cur, prv;  // monitor-side state after this edge / previous edge

  logic [6:0] segtab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void clear_state(output mstate_t s);
    s.s1   = 0;
    s.s2   = 0;
    s.over = 1'b0;
    s.win  = 2'b00;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    int         idx;
    int         tens, ones;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    exp_t       e;
    clear_state(cur);
    clear_state(prv);
    forever begin
      @(negedge clk);
      if (!clr_n) begin
        clear_state(cur);
        clear_state(prv);
        chk("rst_pl1", sk.pl1_score, 8'h00);
        chk("rst_pl2", sk.pl2_score, 8'h00);
        chk("rst_winner", sk.winner, 2'b00);
        chk("rst_over", sk.match_over, 1'b0);
        chk("rst_an", sk.an, 4'b1110);
        chk("rst_seg", sk.seg, 7'b1000000);
        chk("rst_dp", sk.dp, 1'b1);
      end else begin
        prv = cur;
        while (q.size() > 0 && q[0].due <= cyc) begin
          e   = q.pop_front();
          cur = e.st;
        end
        chk("pl1_score", sk.pl1_score, to_bcd(cur.s1));
        chk("pl2_score", sk.pl2_score, to_bcd(cur.s2));
        chk("match_over", sk.match_over, cur.over);
        chk("winner", sk.winner, cur.win);
        // The display registers were loaded at this edge from the previous edge's state and index.
        idx = ((cyc - 1) / DIV) % 4;
        case (idx)
          0: begin e_an = 4'b1110; ones = prv.s2 % 10; e_seg = segtab[ones]; end
          1: begin e_an = 4'b1101; tens = prv.s2 / 10; e_seg = (tens == 0) ? 7'h7F : segtab[tens]; end
          2: begin e_an = 4'b1011; ones = prv.s1 % 10; e_seg = segtab[ones]; end
          default: begin e_an = 4'b0111; tens = prv.s1 / 10; e_seg = (tens == 0) ? 7'h7F : segtab[tens]; end
        endcase
        e_dp = !(prv.over && ((idx == 2 && prv.win[0]) || (idx == 0 && prv.win[1])));
        chk("an", sk.an, e_an);
        chk("seg", sk.seg, e_seg);
        chk("dp", sk.dp, e_dp);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge. The inputs are sampled at the next edge, and the new state is due 3 edges later.
  task automatic ev(input bit g1, input bit g2, input bit rs, input int hold, input int low);
    exp_t e;
    e.due = cyc + 2;
    e.st  = m;
    q.push_back(e);
    if (rs) begin
      clear_state(m);
    end else if (!m.over) begin
      if (g1) m.s1++;
      if (g2) m.s2++;
      if (m.s1 == WIN || m.s2 == WIN) begin
        m.over = 1'b1;
        m.win  = {m.s2 == WIN, m.s1 == WIN};
      end
    end
    e.due = cyc + 3;
    e.st  = m;
    q.push_back(e);
    sk.pl1_goal = g1;
    sk.pl2_goal = g2;
    sk.restart  = rs;
    repeat (hold) @(negedge clk);
    sk.pl1_goal = 1'b0;
    sk.pl2_goal = 1'b0;
    sk.restart  = 1'b0;
    repeat (low) @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic reset_mid_scan();
    drain();
    for (int t = 0; t < 20 && (((cyc - 1) / DIV) % 4) != 2; t++) @(negedge clk);
    @(posedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("async_an", sk.an, 4'b1110);
    chk("async_seg", sk.seg, 7'b1000000);
    chk("async_pl1", sk.pl1_score, 8'h00);
    q.delete();
    clear_state(m);
    repeat (3) @(negedge clk);
    #1 clr_n = 1'b1;
  endtask

  initial begin
    bit g1, g2, rs;
    int kind;
    sk.pl1_goal = 1'b0;
    sk.pl2_goal = 1'b0;
    sk.restart  = 1'b0;
    clear_state(m);
    repeat (3) @(negedge clk);
    #1 clr_n = 1'b1;
    repeat (10) @(negedge clk);           // no spurious goal after release

    ev(1, 0, 0, 3, 2);                    // single goal
    ev(1, 0, 0, 9, 3);                    // held level counts once
    repeat (10) ev(0, 1, 0, 2, 2);        // pl2 carries to 10
    repeat (20) @(negedge clk);
    repeat (10) ev(1, 0, 0, 2, 2);        // pl1 reaches 12 and wins
    ev(1, 0, 0, 2, 2);                    // ignored
    ev(0, 1, 0, 3, 2);                    // ignored
    repeat (20) @(negedge clk);
    ev(0, 0, 1, 2, 2);                    // restart from OVER
    repeat (12) ev(1, 1, 0, 2, 2);        // both reach 12 together: tie
    repeat (20) @(negedge clk);
    ev(1, 0, 1, 3, 2);                    // restart beats coincident goal
    repeat (6) @(negedge clk);
    ev(0, 1, 0, 2, 2);
    reset_mid_scan();
    repeat (6) @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      g1   = $urandom_range(0, 1) != 0;
      g2   = $urandom_range(0, 1) != 0;
      rs   = (kind <= 1);
      if (kind == 0) begin
        g1 = 1'b0;
        g2 = 1'b0;
      end else if (!g1 && !g2) begin
        g1 = 1'b1;
      end
      ev(g1, g2, rs, $urandom_range(2, 5), $urandom_range(2, 4));
    end

    drain();
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Match scoring and 7-segment readout stage downstream of the `game` block. Consumes the `pl1_goal`/`pl2_goal` goal flags and the `restart_game` request from the VGA controller. Keeps per-player BCD scores and declares a winner at a fixed goal count. Drives the board's 4-digit multiplexed 7-segment display, replacing the disabled `segdisplay` path in `NERP_demo_top`.

## Interface
- `WIN_SCORE`, 7: goals needed to win a match; legal range 1–99.
- `REFRESH_DIV`, 100000: `clk` cycles per digit; 500 Hz digit step at 50 MHz. Use 4 in simulation.
- `clk`  in  1  master clock, 50 MHz.
- `clr_n`  in  1  asynchronous, active-low reset.
- `pl1_goal`  in  1  level from `game`; each rising edge is one goal for player 1. Asynchronous to `clk` (game clock domain).
- `pl2_goal`  in  1  same as `pl1_goal`, for player 2.
- `restart`  in  1  level; each rising edge clears the scores and starts a new match.
- `pl1_score`  out  8  player 1 score, BCD {tens, ones}.
- `pl2_score`  out  8  player 2 score, BCD {tens, ones}.
- `match_over`  out  1  high while state is OVER.
- `winner`  out  2  2'b01 = player 1, 2'b10 = player 2, 2'b11 = tie, 2'b00 = none.
- `seg`  out  7  {g,f,e,d,c,b,a}, active-low.
- `an`  out  4  digit enables, active-low.
- `dp`  out  1  decimal point, active-low.

## Operation
- **Input conditioning:** each of `pl1_goal`, `pl2_goal` and `restart` passes through a 2-flop synchronizer and then a delay flop. The event pulse is `s2 & ~s3`, exactly one `clk` cycle per rising edge.
- **FSM states:** PLAY and OVER.
  - PLAY: on a goal pulse, increment that player's BCD score. Ones digit wraps 9→0 and carries into tens.
  - PLAY→OVER: on the update where either new score equals `WIN_SCORE`.
  - OVER: goal pulses are ignored and scores hold.
  - Any state → PLAY on a restart pulse: both scores clear to 0 and `winner` clears to 2'b00.
- **Simultaneous events:**
  - Both goal pulses in the same cycle: both scores increment.
  - If both reach `WIN_SCORE` on that update, `winner` = 2'b11.
  - Restart pulse coincident with a goal pulse: restart wins and the goal is discarded.
- **Display scan:**
  - A refresh counter runs 0..`REFRESH_DIV`-1. On wrap, the 2-bit digit index increments (3→0 wraps).
  - Index 0 → `an`=1110, pl2 ones. Index 1 → `an`=1101, pl2 tens. Index 2 → `an`=1011, pl1 ones. Index 3 → `an`=0111, pl1 tens.
  - Tens digits are blanked (`seg`=7'h7F) when zero.
- **Segment codes:**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- **Decimal point:** `dp`=0 only when `match_over`=1 and the active digit is the winner's ones digit (index 2 for pl1, index 0 for pl2; both on a tie). Otherwise `dp`=1.
- **Reset (`clr_n` low):** asynchronous; all flops clear.
  - Outputs: scores 0, state PLAY, `match_over`=0, `winner`=00.
  - Display: index 0, `an`=1110, `seg`=1000000, `dp`=1.
  - Synchronizer flops clear to 0, so an input already high at reset release counts as one event.

## Timing
- An input high at rising edge k gives: s1=1 at edge k, event pulse during cycle k+1→k+2, score register updated at edge k+2.
- `match_over` and `winner` update at the same edge as the winning score, edge k+2.
- Minimum input high time: 2 `clk` cycles. Minimum low time between events: 2 `clk` cycles.
- `seg`, `an` and `dp` are registered and change together, one cycle after the digit index changes.
- A digit is held for exactly `REFRESH_DIV` cycles.

## Test plan
- **Reset:** with `clr_n`=0, expect scores 00, `an`=1110, `seg`=1000000, `dp`=1, `winner`=00. Release reset: no spurious goal is counted.
- **Single goal:** one 3-cycle `pl1_goal` pulse → `pl1_score`=8'h01 exactly 2 edges after the first sampled-high edge. `pl2_score` stays 8'h00. A held-high level counts only once.
- **Carry:** with `WIN_SCORE`=12, give pl2 ten goals → `pl2_score`=8'h10. Tens digit shows "1". pl1 tens digit is blank.
- **Win:** with `WIN_SCORE`=7, give pl1 7 goals → `match_over`=1 and `winner`=01 at the 7th update.
  - An 8th `pl1_goal` and any `pl2_goal` are ignored.
  - `dp`=0 only while `an`=1011.
- **Simultaneous:** pl1 and pl2 both at 6, `WIN_SCORE`=7, both goals pulsed in the same cycle → both scores 7, `winner`=11. Next, `restart` coincident with `pl1_goal` → scores 00, PLAY, `winner`=00.
- **Scan:** with `REFRESH_DIV`=4, `an` cycles 1110→1101→1011→0111→1110, each digit held 4 cycles. Assert `clr_n` low mid-scan → index returns to 0 immediately.
